// File: rtl/memory_port_arbiter_if.sv
// Memory-side bus between memory_port_arbiter (master) and the unified
// single-ported memory (slave).
interface memory_port_arbiter_if;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteEnable;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output mem_request, mem_write, mem_address, mem_wdata, mem_byteEnable,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_request, mem_write, mem_address, mem_wdata, mem_byteEnable,
        output mem_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory between the fetch port
// and the load/store port. One transaction in flight; data side wins unless
// fetch has been passed over STARVE_LIMIT times in a row.
// Optional build macro MEM_ARB_WATCHDOG_EN adds a timeout on ISSUE/WAIT that
// aborts the transaction with a bus_error pulse.
module memory_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_WATCHDOG_EN
    , parameter int unsigned WATCHDOG_CYCLES = 256
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         i_request,
    input  logic [31:0]                  i_address,
    output logic [31:0]                  i_data,
    output logic                         i_valid,
    input  logic                         loadValid,
    input  logic                         storeValid,
    input  logic [31:0]                  d_address,
    input  logic [31:0]                  storeData,
    input  logic [3:0]                   byteEnable,
    output logic [31:0]                  loadData,
    output logic                         loadDataValid,
    output logic                         storeComplete,
    output logic                         bus_error,
    memory_port_arbiter_if.master        mem
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;
    typedef enum logic [1:0] {OwnFetch, OwnLoad, OwnStore} owner_t;

    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int unsigned   WW      = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
    logic [WW-1:0] wd_cnt;
`endif

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic          fetch_dropped;   // fetch in flight was flushed; swallow its response

    logic fetch_req;
    logic fetch_forced;
    logic grant_store;
    logic grant_load;
    logic grant_fetch;

    // Arbitration among the three requesters, evaluated only while idle.
    always_comb begin
        fetch_req    = i_request & ~flush;
        fetch_forced = fetch_req & (starve_cnt == STARVE_MAX);
        grant_store  = storeValid & ~fetch_forced;
        grant_load   = loadValid & ~storeValid & ~fetch_forced;
        grant_fetch  = fetch_req & (fetch_forced | (~storeValid & ~loadValid));
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= StIdle;
            owner              <= OwnFetch;
            starve_cnt         <= '0;
            fetch_dropped      <= 1'b0;
            i_data             <= '0;
            i_valid            <= 1'b0;
            loadData           <= '0;
            loadDataValid      <= 1'b0;
            storeComplete      <= 1'b0;
            mem.mem_request    <= 1'b0;
            mem.mem_write      <= 1'b0;
            mem.mem_address    <= '0;
            mem.mem_wdata      <= '0;
            mem.mem_byteEnable <= 4'h0;
`ifdef MEM_ARB_WATCHDOG_EN
            wd_cnt             <= '0;
            bus_error          <= 1'b0;
`endif
        end else begin
            i_valid       <= 1'b0;
            loadDataValid <= 1'b0;
            storeComplete <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
            bus_error     <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    fetch_dropped <= 1'b0;
                    if (!i_request || grant_fetch) begin
                        starve_cnt <= '0;
                    end else if ((grant_store || grant_load) && starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (grant_store || grant_load || grant_fetch) begin
                        state           <= StIssue;
                        mem.mem_request <= 1'b1;
                    end
                    if (grant_store) begin
                        owner              <= OwnStore;
                        mem.mem_write      <= 1'b1;
                        mem.mem_address    <= d_address;
                        mem.mem_wdata      <= storeData;
                        mem.mem_byteEnable <= byteEnable;
                    end else if (grant_load) begin
                        owner              <= OwnLoad;
                        mem.mem_write      <= 1'b0;
                        mem.mem_address    <= d_address;
                        mem.mem_wdata      <= '0;
                        mem.mem_byteEnable <= 4'hF;
                    end else if (grant_fetch) begin
                        owner              <= OwnFetch;
                        mem.mem_write      <= 1'b0;
                        mem.mem_address    <= i_address;
                        mem.mem_wdata      <= '0;
                        mem.mem_byteEnable <= 4'hF;
                    end
                end
                StIssue: begin
                    if (mem.mem_ready) begin
                        // Already accepted by memory: must still consume the response.
                        mem.mem_request <= 1'b0;
                        state           <= StWait;
                        if (owner == OwnFetch && flush) fetch_dropped <= 1'b1;
                    end else if (owner == OwnFetch && flush) begin
                        mem.mem_request <= 1'b0;
                        state           <= StIdle;
                    end
                end
                StWait: begin
                    if (mem.mem_rvalid) begin
                        state <= StIdle;
                        unique case (owner)
                            OwnFetch: begin
                                i_data  <= mem.mem_rdata;
                                i_valid <= ~(fetch_dropped | flush);
                            end
                            OwnLoad: begin
                                loadData      <= mem.mem_rdata;
                                loadDataValid <= 1'b1;
                            end
                            OwnStore: storeComplete <= 1'b1;
                            default: ;
                        endcase
                    end else if (owner == OwnFetch && flush) begin
                        fetch_dropped <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef MEM_ARB_WATCHDOG_EN
            // Timeout overrides anything the FSM decided this cycle.
            if (state == StIdle) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_LAST) begin
                wd_cnt          <= '0;
                bus_error       <= 1'b1;
                state           <= StIdle;
                mem.mem_request <= 1'b0;
                i_valid         <= 1'b0;
                loadDataValid   <= 1'b0;
                storeComplete   <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

`ifndef MEM_ARB_WATCHDOG_EN
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a vector table of single
// transactions plus hand-written priority, starvation, flush and reset cases.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        i_request = 1'b0;
    logic [31:0] i_address = '0;
    logic        loadValid = 1'b0;
    logic        storeValid = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] storeData = '0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] i_data;
    logic        i_valid;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;
    logic        bus_error;

    int n_cmp = 0;
    int n_err = 0;

    memory_port_arbiter_if bus ();

    always #5 clock = ~clock;

    memory_port_arbiter #(
        .STARVE_LIMIT(4)
`ifdef MEM_ARB_WATCHDOG_EN
        , .WATCHDOG_CYCLES(8)
`endif
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .i_request     (i_request),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .loadValid     (loadValid),
        .storeValid    (storeValid),
        .d_address     (d_address),
        .storeData     (storeData),
        .byteEnable    (byteEnable),
        .loadData      (loadData),
        .loadDataValid (loadDataValid),
        .storeComplete (storeComplete),
        .bus_error     (bus_error),
        .mem           (bus)
    );

    typedef struct {
        int unsigned kind;      // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int unsigned lat;
        logic        exp_write;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] last_load = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_request) break;
            tick();
        end
        check(name, {31'd0, bus.mem_request}, 32'd1);
    endtask

    task automatic accept();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.mem_rdata  = data;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        if (v.kind == 0) begin
            i_request = 1'b1;
            i_address = v.addr;
        end else begin
            loadValid  = (v.kind == 1);
            storeValid = (v.kind == 2);
            d_address  = v.addr;
            storeData  = v.wdata;
            byteEnable = v.be;
        end
        wait_grant("vec_grant");
        check("vec_mem_write", {31'd0, bus.mem_write}, {31'd0, v.exp_write});
        check("vec_mem_address", bus.mem_address, v.addr);
        check("vec_mem_be", {28'd0, bus.mem_byteEnable}, {28'd0, v.exp_be});
        check("vec_mem_wdata", bus.mem_wdata, v.exp_wdata);
        accept();
        check("vec_req_drop", {31'd0, bus.mem_request}, 32'd0);
        check("vec_no_early_valid", {29'd0, i_valid, loadDataValid, storeComplete}, 32'd0);
        repeat (v.lat - 1) tick();
        respond(v.rdata);
        check("vec_valids", {29'd0, i_valid, loadDataValid, storeComplete},
              {29'd0, v.kind == 0, v.kind == 1, v.kind == 2});
        if (v.kind == 0) check("vec_i_data", i_data, v.exp_data);
        else if (v.kind == 1) begin
            check("vec_loadData", loadData, v.exp_data);
            last_load = v.exp_data;
        end else check("vec_loadData_hold", loadData, last_load);
        i_request  = 1'b0;
        loadValid  = 1'b0;
        storeValid = 1'b0;
        tick();
        check("vec_pulse_end", {29'd0, i_valid, loadDataValid, storeComplete}, 32'd0);
    endtask

    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;

        vecs[0] = '{0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013, 2, 1'b0, 4'hF, 32'h0, 32'h0000_0013};
        vecs[1] = '{1, 32'h0000_2000, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D};
        vecs[2] = '{2, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 32'h0, 3, 1'b1, 4'b0011,
                    32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1, 32'h0000_0004, 32'h0, 4'h0, 32'h1234_5678, 4, 1'b0, 4'hF, 32'h0, 32'h1234_5678};
        vecs[4] = '{0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 1, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF};
        vecs[5] = '{2, 32'h0000_0010, 32'hA5A5_A5A5, 4'b1000, 32'h0, 2, 1'b1, 4'b1000,
                    32'hA5A5_A5A5, 32'h0};

        // Reset state.
        #1 reset = 1'b1;
        #1;
        check("rst_valids", {28'd0, i_valid, loadDataValid, storeComplete, bus_error}, 32'd0);
        check("rst_mem_ctl", {30'd0, bus.mem_request, bus.mem_write}, 32'd0);
        check("rst_mem_addr", bus.mem_address, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_byteEnable}, 32'd0);
        check("rst_data", i_data | loadData, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Store and fetch raised together: store first, then fetch.
        storeValid = 1'b1;
        d_address  = 32'h200;
        storeData  = 32'hDEAD_BEEF;
        byteEnable = 4'b0011;
        i_request  = 1'b1;
        i_address  = 32'h300;
        wait_grant("prio_grant1");
        check("prio_store_first", {31'd0, bus.mem_write}, 32'd1);
        check("prio_store_addr", bus.mem_address, 32'h200);
        check("prio_store_be", {28'd0, bus.mem_byteEnable}, 32'h3);
        accept();
        respond(32'h0);
        check("prio_store_done", {30'd0, storeComplete, i_valid}, 32'b10);
        storeValid = 1'b0;
        wait_grant("prio_grant2");
        check("prio_fetch_next", {bus.mem_write, bus.mem_address[30:0]}, 32'h300);
        accept();
        respond(32'h0000_0013);
        check("prio_fetch_done", {i_valid, i_data[30:0]}, 32'h8000_0013);
        i_request = 1'b0;
        tick();

        // Starvation guard: load held with fetch pending.
        loadValid = 1'b1;
        d_address = 32'h500;
        i_request = 1'b1;
        i_address = 32'h600;
        for (int g = 0; g < 5; g++) begin
            wait_grant("starve_grant");
            check("starve_owner", bus.mem_address, (g < 4) ? 32'h500 : 32'h600);
            accept();
            respond(32'(g));
            check("starve_valid", {30'd0, loadDataValid, i_valid}, (g < 4) ? 32'b10 : 32'b01);
        end
        i_request = 1'b0;
        loadValid = 1'b0;
        tick();

        // Flush while fetch is in WAIT: response swallowed, pending load next.
        i_request = 1'b1;
        i_address = 32'h700;
        wait_grant("fw_grant");
        accept();
        loadValid = 1'b1;
        d_address = 32'h800;
        flush     = 1'b1;
        i_request = 1'b0;
        tick();
        flush = 1'b0;
        respond(32'h1111_1111);
        check("fw_no_ivalid", {31'd0, i_valid}, 32'd0);
        wait_grant("fw_load_grant");
        check("fw_load_addr", bus.mem_address, 32'h800);
        accept();
        respond(32'h2222_2222);
        check("fw_load_done", {31'd0, loadDataValid}, 32'd1);
        check("fw_load_data", loadData, 32'h2222_2222);
        loadValid = 1'b0;
        tick();

        // Flush in IDLE blocks a fetch grant, then flush in ISSUE withdraws it.
        i_request = 1'b1;
        i_address = 32'h900;
        flush     = 1'b1;
        tick();
        check("fi_idle_block", {31'd0, bus.mem_request}, 32'd0);
        flush = 1'b0;
        wait_grant("fi_grant");
        flush     = 1'b1;
        i_request = 1'b0;
        tick();
        flush = 1'b0;
        check("fi_withdraw", {31'd0, bus.mem_request}, 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        check("fi_no_access", {31'd0, bus.mem_request}, 32'd0);
        respond(32'h0000_0BAD);
        check("fi_stray_rvalid", {31'd0, i_valid}, 32'd0);
        check("fi_i_data_hold", i_data, 32'h1111_1111);

        // Reset mid-transaction: in-flight load never reported.
        loadValid = 1'b1;
        d_address = 32'hA00;
        wait_grant("rm_grant");
        accept();
        loadValid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rm_async_clear", {bus.mem_address[30:0], bus.mem_write}, 32'd0);
        tick();
        reset = 1'b0;
        respond(32'h3333_3333);
        check("rm_no_valid", {31'd0, loadDataValid}, 32'd0);
        check("rm_loadData", loadData, 32'd0);
        check("rm_bus_error", {31'd0, bus_error}, 32'd0);

`ifdef MEM_ARB_WATCHDOG_EN
        // Watchdog: memory never accepts.
        i_request = 1'b1;
        i_address = 32'hB00;
        wait_grant("wd_grant");
        repeat (7) tick();
        check("wd_not_yet", {31'd0, bus_error}, 32'd0);
        tick();
        i_request = 1'b0;
        check("wd_bus_error", {30'd0, bus_error, bus.mem_request}, 32'b10);
        tick();
        check("wd_pulse_end", {31'd0, bus_error}, 32'd0);
        respond(32'h4444_4444);
        check("wd_late_rvalid", {31'd0, i_valid}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
